cascade_controller_n: RTL and testbench

Parametrised, clocked cascade controller for the 8259A-style PIC. It sequences INTA pulses, drives or compares the CAS bus depending on master/slave role, and selects which device supplies the interrupt vector. It supports configurable CAS width, 8086 (2-pulse) and 8080 (3-pulse) acknowledge modes, and a sequence-abort timeout. It sits between the control logic (INTA strobes, acknowledged IR index) and the top-level CAS tristate pads.

---
 rtl/cascade_controller_n.sv | 206 ++++++++++++++++++++
 tb/tb_cascade_controller_n.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cascade_controller_n.sv
// cascade_controller_n
//   Cascade sequencer for an 8259A-style PIC. Counts INTA strobes through an
//   acknowledge sequence, drives the CAS bus (master) or compares it against
//   its own ID (slave), and decides which device supplies the vector.
//
// Ports
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   sp_master     1 = master role, 0 = slave role
//   mode_8086     1 = 2 INTA pulses per sequence, 0 = 3 pulses
//   icw3          master: slave-present mask per IR; slave: [CAS_W-1:0] = own ID
//   irq_level     IR index being acknowledged (master), sampled on 1st strobe
//   inta_strobe   single-cycle pulse per INTA falling edge (already synchronous)
//   cas_in        CAS pad input (asynchronous, synchronised here)
//   cas_out       value for the CAS pads when cas_oe = 1
//   cas_oe        CAS pad output enable (master with cascaded IR only)
//   master_vec_en master supplies the vector (IR not cascaded)
//   slave_sel     this slave is addressed and supplies the vector
//   busy          sequence in progress
//   seq_done      one-cycle pulse on normal completion
//   timeout_err   one-cycle pulse when a sequence is abandoned by timeout
module cascade_controller_n #(
   parameter int CAS_W   = 3,
   parameter int TIMEOUT = 64,
   localparam int NUM_IR = 2 ** CAS_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sp_master,
   input  logic              mode_8086,
   input  logic [NUM_IR-1:0] icw3,
   input  logic [CAS_W-1:0]  irq_level,
   input  logic              inta_strobe,
   input  logic [CAS_W-1:0]  cas_in,
   output logic [CAS_W-1:0]  cas_out,
   output logic              cas_oe,
   output logic              master_vec_en,
   output logic              slave_sel,
   output logic              busy,
   output logic              seq_done,
   output logic              timeout_err
);

   localparam int TW = $clog2(TIMEOUT);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] CAS_PHASE = 2'd1;
   localparam logic [1:0] VEC_PHASE = 2'd2;
   localparam logic [1:0] DONE      = 2'd3;

   logic [1:0]       state_reg, state_next;
   logic [1:0]       count_reg, count_next;
   logic [TW-1:0]    tmo_reg, tmo_next;
   logic             mode_reg, mode_next;      // latched mode_8086
   logic             role_reg, role_next;      // sp_master at sequence start
   logic [CAS_W-1:0] id_reg, id_next;          // latched slave ID
   logic [CAS_W-1:0] cas_sync1_reg, cas_sync_reg;

   logic [CAS_W-1:0] cas_out_reg, cas_out_next;
   logic             cas_oe_reg, cas_oe_next;
   logic             mve_reg, mve_next;
   logic             slave_sel_reg, slave_sel_next;
   logic             busy_reg, busy_next;
   logic             seq_done_reg, seq_done_next;
   logic             timeout_err_reg, timeout_err_next;

   logic [1:0]       last_count;
   logic [1:0]       count_inc;

   assign last_count = mode_reg ? 2'd2 : 2'd3;
   assign count_inc  = count_reg + 2'd1;

   always_comb begin
      state_next       = state_reg;
      count_next       = count_reg;
      tmo_next         = tmo_reg;
      mode_next        = mode_reg;
      role_next        = role_reg;
      id_next          = id_reg;
      cas_out_next     = cas_out_reg;
      cas_oe_next      = cas_oe_reg;
      mve_next         = mve_reg;
      slave_sel_next   = slave_sel_reg;
      seq_done_next    = 1'b0;
      timeout_err_next = 1'b0;

      case (state_reg)
         IDLE: begin
            if (inta_strobe) begin
               state_next     = CAS_PHASE;
               count_next     = 2'd1;
               tmo_next       = '0;
               mode_next      = mode_8086;
               role_next      = sp_master;
               id_next        = icw3[CAS_W-1:0];
               slave_sel_next = 1'b0;
               cas_out_next   = '0;
               cas_oe_next    = 1'b0;
               mve_next       = 1'b0;
               if (sp_master) begin
                  if (icw3[irq_level]) begin
                     cas_out_next = irq_level;
                     cas_oe_next  = 1'b1;
                  end else begin
                     mve_next = 1'b1;
                  end
               end
            end
         end

         CAS_PHASE, VEC_PHASE: begin
            if (sp_master != role_reg) begin
               // Role flipped mid-sequence: drop everything silently.
               state_next     = IDLE;
               count_next     = '0;
               tmo_next       = '0;
               cas_out_next   = '0;
               cas_oe_next    = 1'b0;
               mve_next       = 1'b0;
               slave_sel_next = 1'b0;
            end else if (inta_strobe) begin
               // A strobe always beats a coincident timeout expiry.
               count_next = count_inc;
               tmo_next   = '0;
               if (count_reg == 2'd1 && !role_reg)
                  slave_sel_next = (cas_sync_reg == id_reg);
               if (count_inc == last_count) begin
                  state_next    = DONE;
                  seq_done_next = 1'b1;
               end else begin
                  state_next = VEC_PHASE;
               end
            end else if (tmo_reg == TW'(TIMEOUT - 2)) begin
               // Counter would reach TIMEOUT-1 this edge: abandon.
               state_next       = IDLE;
               count_next       = '0;
               tmo_next         = '0;
               cas_out_next     = '0;
               cas_oe_next      = 1'b0;
               mve_next         = 1'b0;
               slave_sel_next   = 1'b0;
               timeout_err_next = 1'b1;
            end else begin
               tmo_next = tmo_reg + TW'(1);
            end
         end

         default: begin  // DONE: strobes here are ignored
            state_next     = IDLE;
            count_next     = '0;
            tmo_next       = '0;
            cas_out_next   = '0;
            cas_oe_next    = 1'b0;
            mve_next       = 1'b0;
            slave_sel_next = 1'b0;
         end
      endcase

      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg       <= IDLE;
         count_reg       <= '0;
         tmo_reg         <= '0;
         mode_reg        <= 1'b0;
         role_reg        <= 1'b0;
         id_reg          <= '0;
         cas_sync1_reg   <= '0;
         cas_sync_reg    <= '0;
         cas_out_reg     <= '0;
         cas_oe_reg      <= 1'b0;
         mve_reg         <= 1'b0;
         slave_sel_reg   <= 1'b0;
         busy_reg        <= 1'b0;
         seq_done_reg    <= 1'b0;
         timeout_err_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         count_reg       <= count_next;
         tmo_reg         <= tmo_next;
         mode_reg        <= mode_next;
         role_reg        <= role_next;
         id_reg          <= id_next;
         cas_sync1_reg   <= cas_in;
         cas_sync_reg    <= cas_sync1_reg;
         cas_out_reg     <= cas_out_next;
         cas_oe_reg      <= cas_oe_next;
         mve_reg         <= mve_next;
         slave_sel_reg   <= slave_sel_next;
         busy_reg        <= busy_next;
         seq_done_reg    <= seq_done_next;
         timeout_err_reg <= timeout_err_next;
      end
   end

   assign cas_out       = cas_out_reg;
   assign cas_oe        = cas_oe_reg;
   assign master_vec_en = mve_reg;
   assign slave_sel     = slave_sel_reg;
   assign busy          = busy_reg;
   assign seq_done      = seq_done_reg;
   assign timeout_err   = timeout_err_reg;

endmodule

// File: tb/tb_cascade_controller_n.sv
// Directed bench for cascade_controller_n (CAS_W=3, TIMEOUT=16).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_cascade_controller_n;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       sp_master = 1'b1;
   logic       mode_8086 = 1'b1;
   logic [7:0] icw3 = 8'h00;
   logic [2:0] irq_level = 3'd0;
   logic       inta_strobe = 1'b0;
   logic [2:0] cas_in = 3'd0;
   logic [2:0] cas_out;
   logic       cas_oe, master_vec_en, slave_sel, busy, seq_done, timeout_err;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   cascade_controller_n #(.CAS_W(3), .TIMEOUT(16)) dut (
      .clk(clk), .reset_n(reset_n), .sp_master(sp_master), .mode_8086(mode_8086),
      .icw3(icw3), .irq_level(irq_level), .inta_strobe(inta_strobe), .cas_in(cas_in),
      .cas_out(cas_out), .cas_oe(cas_oe), .master_vec_en(master_vec_en),
      .slave_sel(slave_sel), .busy(busy), .seq_done(seq_done), .timeout_err(timeout_err)
   );

   // Pack all outputs: {cas_out[2:0], cas_oe, mve, slave_sel, busy, seq_done, timeout_err}
   function automatic logic [8:0] outs();
      return {cas_out, cas_oe, master_vec_en, slave_sel, busy, seq_done, timeout_err};
   endfunction

   // Called at a falling edge: strobe is sampled on the next rising edge,
   // returns at the following falling edge with the result visible.
   task automatic strobe();
      inta_strobe = 1'b1;
      @(negedge clk);
      inta_strobe = 1'b0;
      $display("[%0t] strobe: outs=%b", $time, outs());
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      idle(3);
      total++;
      if (outs() !== 9'b0) begin
         bad++;
         $display("FAIL reset_outs got=%b want=%b", outs(), 9'b0);
      end
      reset_n = 1'b1;
      idle(2);
      total++;
      if (outs() !== 9'b0) begin
         bad++;
         $display("FAIL idle_outs got=%b want=%b", outs(), 9'b0);
      end
   endtask

   task automatic test_master_8086();
      sp_master = 1'b1; mode_8086 = 1'b1; icw3 = 8'h04; irq_level = 3'd2;
      strobe();
      total++;
      if (outs() !== {3'd2, 6'b100100}) begin
         bad++;
         $display("FAIL m86_first got=%b want=%b", outs(), {3'd2, 6'b100100});
      end
      irq_level = 3'd7; // must be ignored after the first strobe
      idle(4);
      total++;
      if (outs() !== {3'd2, 6'b100100}) begin
         bad++;
         $display("FAIL m86_hold got=%b want=%b", outs(), {3'd2, 6'b100100});
      end
      strobe();
      total++;
      if (outs() !== {3'd2, 6'b100110}) begin
         bad++;
         $display("FAIL m86_done got=%b want=%b", outs(), {3'd2, 6'b100110});
      end
      idle(1);
      total++;
      if (outs() !== 9'b0) begin
         bad++;
         $display("FAIL m86_after got=%b want=%b", outs(), 9'b0);
      end
   endtask

   task automatic test_master_8080();
      sp_master = 1'b1; mode_8086 = 1'b0; icw3 = 8'h00; irq_level = 3'd5;
      strobe();
      total++;
      if (outs() !== {3'd0, 6'b010100}) begin
         bad++;
         $display("FAIL m80_p1 got=%b want=%b", outs(), {3'd0, 6'b010100});
      end
      mode_8086 = 1'b1; // latched value (3 pulses) must still apply
      idle(2);
      strobe();
      total++;
      if (outs() !== {3'd0, 6'b010100}) begin
         bad++;
         $display("FAIL m80_p2 got=%b want=%b", outs(), {3'd0, 6'b010100});
      end
      idle(2);
      strobe();
      total++;
      if (outs() !== {3'd0, 6'b010110}) begin
         bad++;
         $display("FAIL m80_p3 got=%b want=%b", outs(), {3'd0, 6'b010110});
      end
      idle(1);
      total++;
      if (outs() !== 9'b0) begin
         bad++;
         $display("FAIL m80_after got=%b want=%b", outs(), 9'b0);
      end
   endtask

   task automatic test_slave(input logic [2:0] cas_val, input logic exp_sel);
      sp_master = 1'b0; mode_8086 = 1'b1; icw3 = 8'h03; cas_in = cas_val;
      idle(4);
      strobe();
      icw3 = {5'b0, cas_val}; // later ID changes are ignored
      total++;
      if (outs() !== {3'd0, 6'b000100}) begin
         bad++;
         $display("FAIL slv_p1 cas=%0d got=%b want=%b", cas_val, outs(), {3'd0, 6'b000100});
      end
      idle(3);
      strobe();
      total++;
      if (outs() !== {3'd0, 2'b00, exp_sel, 3'b110}) begin
         bad++;
         $display("FAIL slv_sel cas=%0d got=%b want=%b", cas_val, outs(), {3'd0, 2'b00, exp_sel, 3'b110});
      end
      idle(1);
      total++;
      if (outs() !== 9'b0) begin
         bad++;
         $display("FAIL slv_after cas=%0d got=%b want=%b", cas_val, outs(), 9'b0);
      end
   endtask

   task automatic test_timeout();
      sp_master = 1'b1; mode_8086 = 1'b1; icw3 = 8'h04; irq_level = 3'd2;
      strobe();
      idle(14);
      total++;
      if (outs() !== {3'd2, 6'b100100}) begin
         bad++;
         $display("FAIL tmo_before got=%b want=%b", outs(), {3'd2, 6'b100100});
      end
      idle(1);
      total++;
      if (outs() !== 9'b000000001) begin
         bad++;
         $display("FAIL tmo_pulse got=%b want=%b", outs(), 9'b000000001);
      end
      idle(1);
      total++;
      if (outs() !== 9'b0) begin
         bad++;
         $display("FAIL tmo_after got=%b want=%b", outs(), 9'b0);
      end
   endtask

   task automatic test_strobe_at_timeout();
      sp_master = 1'b1; mode_8086 = 1'b0; icw3 = 8'h00; irq_level = 3'd1;
      strobe();
      idle(14);
      strobe(); // sampled on the expiry edge
      total++;
      if (outs() !== {3'd0, 6'b010100}) begin
         bad++;
         $display("FAIL tmo_race got=%b want=%b", outs(), {3'd0, 6'b010100});
      end
      idle(1);
      strobe();
      total++;
      if (outs() !== {3'd0, 6'b010110}) begin
         bad++;
         $display("FAIL tmo_race_done got=%b want=%b", outs(), {3'd0, 6'b010110});
      end
      idle(1);
   endtask

   task automatic test_async_reset_and_abort();
      sp_master = 1'b1; mode_8086 = 1'b0; icw3 = 8'h04; irq_level = 3'd2;
      strobe();
      strobe();
      total++;
      if (outs() !== {3'd2, 6'b100100}) begin
         bad++;
         $display("FAIL vec_phase got=%b want=%b", outs(), {3'd2, 6'b100100});
      end
      #2 reset_n = 1'b0;
      #1;
      total++;
      if (outs() !== 9'b0) begin
         bad++;
         $display("FAIL async_reset got=%b want=%b", outs(), 9'b0);
      end
      @(negedge clk);
      reset_n = 1'b1;
      strobe(); // accepted on the first edge out of reset
      total++;
      if (outs() !== {3'd2, 6'b100100}) begin
         bad++;
         $display("FAIL post_reset got=%b want=%b", outs(), {3'd2, 6'b100100});
      end
      sp_master = 1'b0;
      idle(1);
      total++;
      if (outs() !== 9'b0) begin
         bad++;
         $display("FAIL role_abort got=%b want=%b", outs(), 9'b0);
      end
      sp_master = 1'b1;
      idle(1);
      total++;
      if (outs() !== 9'b0) begin
         bad++;
         $display("FAIL abort_quiet got=%b want=%b", outs(), 9'b0);
      end
   endtask

   task automatic test_back_to_back();
      sp_master = 1'b1; mode_8086 = 1'b1; icw3 = 8'h00; irq_level = 3'd0;
      strobe();
      strobe();
      total++;
      if (outs() !== {3'd0, 6'b010110}) begin
         bad++;
         $display("FAIL b2b_done got=%b want=%b", outs(), {3'd0, 6'b010110});
      end
      strobe(); // lands in DONE: ignored
      total++;
      if (outs() !== 9'b0) begin
         bad++;
         $display("FAIL b2b_ignored got=%b want=%b", outs(), 9'b0);
      end
      idle(1);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL b2b_idle got=%b want=%b", busy, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_master_8086();
      test_master_8080();
      test_slave(3'd3, 1'b1);
      test_slave(3'd6, 1'b0);
      test_timeout();
      test_strobe_at_timeout();
      test_async_reset_and_abort();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
